// File: rtl/cla_pkg.sv
// Shared constants, propagate/generate pair type and 4-bit lookahead carry functions for cla_adder.
// Purely combinational helpers; no state.
package cla_pkg;

    localparam int GROUP_W       = 4;
    localparam int DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Carry into each bit of a 4-bit group, fully expanded sum-of-products.
    function automatic logic [3:0] lookahead_carries(input pg_t [3:0] pg, input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = pg[0].g | (pg[0].p & cin);
        c[2] = pg[1].g | (pg[1].p & pg[0].g) | (pg[1].p & pg[0].p & cin);
        c[3] = pg[2].g | (pg[2].p & pg[1].g) | (pg[2].p & pg[1].p & pg[0].g)
             | (pg[2].p & pg[1].p & pg[0].p & cin);
        return c;
    endfunction

    function automatic logic group_generate(input pg_t [3:0] pg);
        return pg[3].g | (pg[3].p & pg[2].g) | (pg[3].p & pg[2].p & pg[1].g)
             | (pg[3].p & pg[2].p & pg[1].p & pg[0].g);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate for the second level.
// Latency: combinational. Backpressure: none.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_p,
    output logic       grp_g
);

    pg_t  [3:0] pg;
    logic [3:0] c;

    always_comb begin
        pg = '0;
        for (int i = 0; i < 4; i++) begin
            pg[i].p = a[i] ^ b[i];
            pg[i].g = a[i] & b[i];
        end
    end

    assign c = lookahead_carries(pg, cin);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = pg[i].p ^ c[i];
        end
    end

    assign grp_p = pg[3].p & pg[2].p & pg[1].p & pg[0].p;
    assign grp_g = group_generate(pg);

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder {c_out, Output} = A + B + c_in; CLA_OVERFLOW_EN adds signed ovf.
// Latency: one clk edge when en=1. Backpressure: none; en=0 holds the result and drops ready.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             c_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Output,
    output logic             c_out,
`ifdef CLA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             ready
);

    localparam int NG = WIDTH / GROUP_W;

    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum;
    logic             acc;
    logic             term;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_group4 u_grp (
            .a     (A[g*GROUP_W +: GROUP_W]),
            .b     (B[g*GROUP_W +: GROUP_W]),
            .cin   (gc[g]),
            .sum   (sum[g*GROUP_W +: GROUP_W]),
            .grp_p (gp[g]),
            .grp_g (gg[g])
        );
    end

    // Second level: each group carry-in as a flat OR of products of group P/G and c_in.
    always_comb begin
        gc   = '0;
        acc  = 1'b0;
        term = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            acc = c_in;
            for (int j = 0; j < k; j++) begin
                acc = acc & gp[j];
            end
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            gc[k] = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Output <= '0;
            c_out  <= 1'b0;
            ready  <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
        end else begin
            ready <= en;
            if (en) begin
                Output <= sum;
                c_out  <= gc[NG];
`ifdef CLA_OVERFLOW_EN
                // Carry into the MSB is recovered from its sum bit: c = a ^ b ^ s.
                ovf    <= A[WIDTH-1] ^ B[WIDTH-1] ^ sum[WIDTH-1] ^ gc[NG];
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed table, hold/reset sequences, exhaustive 4-bit and random 8-bit sweeps.
module tb_cla_adder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       c_in;
    logic [3:0] a4, b4, out4;
    logic       cout4, rdy4;
    logic [7:0] a8, b8, out8;
    logic       cout8, rdy8;
`ifdef CLA_OVERFLOW_EN
    logic       ovf4, ovf8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cla_adder #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .c_in   (c_in),
        .A      (a4),
        .B      (b4),
        .Output (out4),
        .c_out  (cout4),
`ifdef CLA_OVERFLOW_EN
        .ovf    (ovf4),
`endif
        .ready  (rdy4)
    );

    cla_adder #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .c_in   (c_in),
        .A      (a8),
        .B      (b8),
        .Output (out8),
        .c_out  (cout8),
`ifdef CLA_OVERFLOW_EN
        .ovf    (ovf8),
`endif
        .ready  (rdy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [3:0] s, input logic co, input logic r);
        check({name, ".out"},   {28'd0, out4},  {28'd0, s});
        check({name, ".cout"},  {31'd0, cout4}, {31'd0, co});
        check({name, ".ready"}, {31'd0, rdy4},  {31'd0, r});
    endtask

    initial begin
        logic [4:0] exp5;
        logic [8:0] exp9;

        vecs[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[2] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[4] = '{4'h5, 4'h3, 1'b1, 4'h9, 1'b0, 1'b1};
        vecs[5] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[7] = '{4'h6, 4'h1, 1'b1, 4'h8, 1'b0, 1'b1};
        vecs[8] = '{4'hC, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[9] = '{4'h9, 4'h9, 1'b1, 4'h3, 1'b1, 1'b1};

        rst_n = 1'b0;
        en    = 1'b0;
        c_in  = 1'b0;
        a4    = 4'h0;
        b4    = 4'h0;
        a8    = 8'h00;
        b8    = 8'h00;
        #3;
        check_state("reset", 4'h0, 1'b0, 1'b0);
`ifdef CLA_OVERFLOW_EN
        check("reset.ovf", {31'd0, ovf4}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // First capture only on an en=1 edge; ready falls after the en=0 edge.
        a4 = 4'h1; b4 = 4'h2; c_in = 1'b0; en = 1'b0;
        step();
        check_state("idle_after_reset", 4'h0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_state("first_en", 4'h3, 1'b0, 1'b1);
        step();
        check_state("second_en", 4'h3, 1'b0, 1'b1);
        en = 1'b0;
        step();
        check_state("en_drop", 4'h3, 1'b0, 1'b0);

        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a4 = vecs[i].a; b4 = vecs[i].b; c_in = vecs[i].cin;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, 1'b1);
`ifdef CLA_OVERFLOW_EN
            check($sformatf("vec%0d.ovf", i), {31'd0, ovf4}, {31'd0, vecs[i].ovf});
`endif
        end

        // Last vector left 3 / c_out=1; operands churn with en=0 must not disturb it.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a4 = 4'(i * 5 + 2); b4 = 4'(15 - i); c_in = i[0];
            step();
            check_state($sformatf("hold%0d", i), 4'h3, 1'b1, 1'b0);
`ifdef CLA_OVERFLOW_EN
            check($sformatf("hold%0d.ovf", i), {31'd0, ovf4}, 32'd1);
`endif
        end

        // Reset between edges clears immediately and leaves nothing pending.
        en = 1'b1; a4 = 4'h7; b4 = 4'h1; c_in = 1'b0;
        step();
        check_state("pre_rst", 4'h8, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 4'h0, 1'b0, 1'b0);
`ifdef CLA_OVERFLOW_EN
        check("async_rst.ovf", {31'd0, ovf4}, 32'd0);
`endif
        step();
        check_state("rst_held", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        step();
        check_state("post_rst", 4'h0, 1'b0, 1'b0);

        en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ta, tb;
            logic       tc;
            ta = 4'(i >> 5); tb = 4'(i >> 1); tc = i[0];
            a4 = ta; b4 = tb; c_in = tc;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            exp5 = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, tc};
            step();
            check($sformatf("sweep4 %h+%h+%0d", ta, tb, tc), {27'd0, cout4, out4}, {27'd0, exp5});
            check($sformatf("rand8 %h+%h+%0d", a8, b8, tc), {23'd0, cout8, out8}, {23'd0, exp9});
`ifdef CLA_OVERFLOW_EN
            check($sformatf("sweep4 ovf %h+%h", ta, tb), {31'd0, ovf4},
                  {31'd0, (ta[3] == tb[3]) && (exp5[3] != ta[3])});
            check($sformatf("rand8 ovf %h+%h", a8, b8), {31'd0, ovf8},
                  {31'd0, (a8[7] == b8[7]) && (exp9[7] != a8[7])});
`endif
        end
        check("sweep.ready4", {31'd0, rdy4}, 32'd1);
        check("sweep.ready8", {31'd0, rdy8}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
